// File: rtl/eth_rx_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkg
// Purpose  : Shared constants and types for the Ethernet RX frame buffer.
//            Holds the write-FSM state encoding, the stored word layout
//            {last, data} and the counter widths.
// Revision : 1.0  initial release
// ============================================================================
package eth_pkg;

  // Write-FSM state encoding
  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  typedef enum logic [1:0] {
    SYNC = ST_SYNC,
    RECV = ST_RECV,
    DROP = ST_DROP
  } wr_state_t;

  // Stored word layout: bit 8 flags the last byte of a frame
  localparam int LAST_BIT   = 8;
  localparam int WORD_W     = 9;

  localparam int DROP_CNT_W = 16;
  localparam int LEN_W      = 16;

endpackage
`default_nettype wire

// File: rtl/eth_rx_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_buffer_if
// Purpose  : Bundles the MAC RX byte stream, the consumer read handshake and
//            the status outputs of eth_rx_buffer.
// Ports    : slave  - the buffer (receives MAC bytes and i_rreq, drives o_*)
//            master - the environment (drives MAC bytes and i_rreq)
// Revision : 1.0  initial release
// ============================================================================
interface eth_rx_buffer_if #(
  parameter int ADDR_W = 11
);

  logic [7:0]                     i_mac_data;
  logic                           i_mac_valid;
  logic                           i_mac_last;
  logic                           i_mac_err;
  logic [7:0]                     o_rdata;
  logic                           o_rready;
  logic                           o_rlast;
  logic                           i_rreq;
  logic [ADDR_W:0]                o_level;
  logic [eth_pkg::DROP_CNT_W-1:0] o_drop_cnt;

  modport slave (
    input  i_mac_data, i_mac_valid, i_mac_last, i_mac_err, i_rreq,
    output o_rdata, o_rready, o_rlast, o_level, o_drop_cnt
  );

  modport master (
    output i_mac_data, i_mac_valid, i_mac_last, i_mac_err, i_rreq,
    input  o_rdata, o_rready, o_rlast, o_level, o_drop_cnt
  );

endinterface
`default_nettype wire

// File: rtl/eth_rx_buffer_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram
// Purpose  : Simple dual-port RAM, one write port and one registered read
//            port on the same clock. The array has no reset.
// Ports    : i_clk            clock
//            i_we/i_waddr/i_wdata  write port
//            i_re/i_raddr     read enable/address; o_rdata updates one clock
//                             later and holds while i_re is low
// Revision : 1.0  initial release
// ============================================================================
module sdp_ram #(
  parameter int ADDR_W = 11,
  parameter int WORD_W = 9
) (
  input  wire               i_clk,
  input  wire               i_we,
  input  wire  [ADDR_W-1:0] i_waddr,
  input  wire  [WORD_W-1:0] i_wdata,
  input  wire               i_re,
  input  wire  [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [2**ADDR_W];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/eth_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_buffer
// Purpose  : Receive frame buffer between the MAC RX byte stream and the
//            protocol engine. Frames are written speculatively and committed
//            only when their last byte arrives clean and long enough; bad,
//            runt and overflowing frames are rolled back and counted.
// Ports    : i_clk, i_rst (async, active-high)
//            bus.i_mac_*  MAC byte stream (no backpressure)
//            bus.o_rdata/o_rlast/o_rready/i_rreq  show-ahead read port
//            bus.o_level  committed bytes not yet read
//            bus.o_drop_cnt  dropped frames, saturating
// Revision : 1.0  initial release
// ============================================================================
module eth_rx_buffer
  import eth_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int MIN_LEN = 14
) (
  input  wire            i_clk,
  input  wire            i_rst,
  eth_rx_buffer_if.slave bus
);

  localparam logic [ADDR_W:0]  c_DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LEN_W-1:0] c_MIN_LEN = LEN_W'(MIN_LEN);

  // ---------------------------------------------------------------- write side
  wr_state_t             r_state, w_state_nxt;
  logic [ADDR_W:0]       r_wr_spec, w_wr_spec_nxt;
  logic [ADDR_W:0]       r_wr_commit, w_wr_commit_nxt;
  logic [ADDR_W:0]       r_rd_ptr;
  logic [LEN_W-1:0]      r_len, w_len_nxt, w_len_inc;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic                  w_we, w_drop_inc, w_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= SYNC;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_full          = (r_wr_spec - r_rd_ptr) == c_DEPTH;
    w_len_inc       = (r_len == '1) ? r_len : r_len + 1'b1;
    w_state_nxt     = r_state;
    w_wr_spec_nxt   = r_wr_spec;
    w_wr_commit_nxt = r_wr_commit;
    w_len_nxt       = r_len;
    w_we            = 1'b0;
    w_drop_inc      = 1'b0;
    case (r_state)
      // Wait for a frame boundary so a frame cut by reset is never committed
      SYNC: begin
        if (bus.i_mac_valid && bus.i_mac_last) begin
          w_state_nxt = RECV;
          w_len_nxt   = '0;
        end
      end
      RECV: begin
        if (bus.i_mac_valid) begin
          if (w_full) begin
            // Overflow: discard the partial frame; a last byte ends it here
            w_wr_spec_nxt = r_wr_commit;
            w_drop_inc    = 1'b1;
            w_len_nxt     = '0;
            if (!bus.i_mac_last) w_state_nxt = DROP;
          end else begin
            w_we = 1'b1;
            if (bus.i_mac_last) begin
              w_len_nxt = '0;
              if (!bus.i_mac_err && (w_len_inc >= c_MIN_LEN)) begin
                w_wr_spec_nxt   = r_wr_spec + 1'b1;
                w_wr_commit_nxt = r_wr_spec + 1'b1;
              end else begin
                w_wr_spec_nxt = r_wr_commit;
                w_drop_inc    = 1'b1;
              end
            end else begin
              w_wr_spec_nxt = r_wr_spec + 1'b1;
              w_len_nxt     = w_len_inc;
            end
          end
        end
      end
      DROP: begin
        if (bus.i_mac_valid && bus.i_mac_last) w_state_nxt = RECV;
      end
      default: w_state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_spec   <= '0;
      r_wr_commit <= '0;
      r_len       <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_wr_spec   <= w_wr_spec_nxt;
      r_wr_commit <= w_wr_commit_nxt;
      r_len       <= w_len_nxt;
      if (w_drop_inc && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // ----------------------------------------------------------------- read side
  // Two-stage show-ahead: RAM output register, then the prefetch register.
  // r_fetch_ptr runs ahead of r_rd_ptr by the words held in those stages;
  // space is only freed on a pop, so in-flight words stay protected.
  logic [ADDR_W:0]   r_fetch_ptr;
  logic              r_ram_vld, r_pf_vld;
  logic [WORD_W-1:0] r_pf_word, w_ram_rdata;
  logic              w_pop, w_pf_load, w_fetch;

  always_comb begin
    w_pop     = bus.i_rreq & r_pf_vld;
    w_pf_load = r_ram_vld & (~r_pf_vld | w_pop);
    w_fetch   = (r_fetch_ptr != r_wr_commit) & (~r_ram_vld | w_pf_load);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr    <= '0;
      r_fetch_ptr <= '0;
      r_ram_vld   <= 1'b0;
      r_pf_vld    <= 1'b0;
      r_pf_word   <= '0;
    end else begin
      if (w_pop)   r_rd_ptr    <= r_rd_ptr + 1'b1;
      if (w_fetch) r_fetch_ptr <= r_fetch_ptr + 1'b1;
      if (w_fetch)        r_ram_vld <= 1'b1;
      else if (w_pf_load) r_ram_vld <= 1'b0;
      if (w_pf_load) begin
        r_pf_vld  <= 1'b1;
        r_pf_word <= w_ram_rdata;
      end else if (w_pop) begin
        r_pf_vld  <= 1'b0;
      end
    end
  end

  sdp_ram #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_spec[ADDR_W-1:0]),
    .i_wdata ({bus.i_mac_last, bus.i_mac_data}),
    .i_re    (w_fetch),
    .i_raddr (r_fetch_ptr[ADDR_W-1:0]),
    .o_rdata (w_ram_rdata)
  );

  assign bus.o_rdata    = r_pf_word[7:0];
  assign bus.o_rlast    = r_pf_vld & r_pf_word[LAST_BIT];
  assign bus.o_rready   = r_pf_vld;
  assign bus.o_level    = r_wr_commit - r_rd_ptr;
  assign bus.o_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_buffer
// Purpose  : Directed self-checking bench for eth_rx_buffer. One instance
//            uses the default depth (2048), a second uses depth 64 for the
//            overflow, wrap and counter-saturation cases; sel picks which
//            instance the shared stimulus and observation signals address.
// Revision : 1.0  initial release
// ============================================================================
module tb_eth_rx_buffer;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  eth_rx_buffer_if #(.ADDR_W(11)) bus_l ();
  eth_rx_buffer_if #(.ADDR_W(6))  bus_s ();

  eth_rx_buffer #(.ADDR_W(11), .MIN_LEN(14)) u_dut_l (
    .i_clk (i_clk), .i_rst (i_rst), .bus (bus_l)
  );
  eth_rx_buffer #(.ADDR_W(6), .MIN_LEN(14)) u_dut_s (
    .i_clk (i_clk), .i_rst (i_rst), .bus (bus_s)
  );

  logic       sel       = 1'b0;
  logic [7:0] mac_data  = 8'h00;
  logic       mac_valid = 1'b0;
  logic       mac_last  = 1'b0;
  logic       mac_err   = 1'b0;
  logic       rreq      = 1'b0;

  assign bus_l.i_mac_data  = mac_data;
  assign bus_l.i_mac_valid = mac_valid & ~sel;
  assign bus_l.i_mac_last  = mac_last;
  assign bus_l.i_mac_err   = mac_err;
  assign bus_l.i_rreq      = rreq & ~sel;
  assign bus_s.i_mac_data  = mac_data;
  assign bus_s.i_mac_valid = mac_valid & sel;
  assign bus_s.i_mac_last  = mac_last;
  assign bus_s.i_mac_err   = mac_err;
  assign bus_s.i_rreq      = rreq & sel;

  wire [7:0]  rdata    = sel ? bus_s.o_rdata    : bus_l.o_rdata;
  wire        rready   = sel ? bus_s.o_rready   : bus_l.o_rready;
  wire        rlast    = sel ? bus_s.o_rlast    : bus_l.o_rlast;
  wire [11:0] level    = sel ? {5'd0, bus_s.o_level} : bus_l.o_level;
  wire [15:0] drop_cnt = sel ? bus_s.o_drop_cnt : bus_l.o_drop_cnt;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic err);
    @(negedge i_clk);
    mac_data = d; mac_valid = 1'b1; mac_last = last; mac_err = err;
  endtask

  task automatic idle(input int n);
    @(negedge i_clk);
    mac_valid = 1'b0; mac_last = 1'b0; mac_err = 1'b0;
    repeat (n - 1) @(negedge i_clk);
  endtask

  task automatic send_frame(input int len, input logic [7:0] base, input logic err, input logic push);
    logic [7:0] d;
    for (int k = 0; k < len; k++) begin
      d = base + 8'(k);
      if (push) exp_q.push_back({(k == len - 1), d});
      send_byte(d, (k == len - 1), err && (k == len - 1));
    end
  endtask

  // Pops every queued byte and compares it; gives up after budget idle cycles
  task automatic drain(input string tag, input int budget);
    int waited;
    logic [8:0] w;
    waited = 0;
    rreq = 1'b1;
    while (exp_q.size() != 0 && waited < budget) begin
      if (rready) begin
        w = exp_q.pop_front();
        check_eq({tag, "_data"}, rdata, w[7:0]);
        check_eq({tag, "_last"}, rlast, w[8]);
      end else begin
        waited++;
      end
      @(negedge i_clk);
    end
    rreq = 1'b0;
    check_eq({tag, "_left"}, exp_q.size(), 0);
  endtask

  task automatic stress(input int nframes);
    int len, cyc, rlast_cnt, max_level;
    logic prod_done, r;
    logic [7:0] d;
    logic [8:0] w;
    rlast_cnt = 0; max_level = 0; prod_done = 1'b0; cyc = 0;
    fork
      begin
        for (int f = 0; f < nframes; f++) begin
          len = $urandom_range(14, 100);
          for (int k = 0; k < len; k++) begin
            d = 8'($urandom);
            exp_q.push_back({(k == len - 1), d});
            send_byte(d, (k == len - 1), 1'b0);
          end
        end
        idle(1);
        prod_done = 1'b1;
      end
      begin
        while (!(prod_done && exp_q.size() == 0) && cyc < 20000) begin
          @(negedge i_clk);
          cyc++;
          if (int'(level) > max_level) max_level = int'(level);
          r = ($urandom_range(0, 3) != 0);
          if (rready && r) begin
            w = exp_q.pop_front();
            check_eq("st_data", rdata, w[7:0]);
            check_eq("st_last", rlast, w[8]);
            if (rlast) rlast_cnt++;
          end
          rreq = r;
        end
        rreq = 1'b0;
      end
    join
    check_eq("st_left", exp_q.size(), 0);
    check_eq("st_rlast_cnt", rlast_cnt, nframes);
    check_eq("st_level_max_ok", (max_level <= 2048), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state
    repeat (3) @(negedge i_clk);
    check_eq("rst_rready", rready, 0);
    check_eq("rst_rlast", rlast, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_drop", drop_cnt, 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // ---- test 1: 20-byte frame, latency, streaming read
    send_byte(8'hFF, 1'b1, 1'b0);          // boundary byte consumed by SYNC
    send_frame(20, 8'h00, 1'b0, 1'b0);
    idle(1);
    check_eq("t1_rdy_e1", rready, 0);
    @(negedge i_clk);
    check_eq("t1_rdy_e2", rready, 0);
    @(negedge i_clk);
    check_eq("t1_rdy_e3", rready, 1);
    rreq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_eq("t1_rready", rready, 1);
      check_eq("t1_data", rdata, i);
      check_eq("t1_last", rlast, (i == 19));
      check_eq("t1_level", level, 20 - i);
      @(negedge i_clk);
    end
    rreq = 1'b0;
    check_eq("t1_rdy_end", rready, 0);
    check_eq("t1_level_end", level, 0);

    // ---- test 2: reset mid-frame, tail must be discarded
    for (int k = 0; k < 5; k++) send_byte(8'(k), 1'b0, 1'b0);
    @(negedge i_clk);
    mac_valid = 1'b0;
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    check_eq("t2_rst_rready", rready, 0);
    check_eq("t2_rst_level", level, 0);
    i_rst = 1'b0;
    for (int k = 5; k < 20; k++) send_byte(8'(k), (k == 19), 1'b0);
    send_frame(16, 8'h40, 1'b0, 1'b1);
    idle(3);
    check_eq("t2_level", level, 16);
    check_eq("t2_drop", drop_cnt, 0);
    drain("t2", 20);

    // ---- test 3: good, error, runt, minimum-length good
    send_frame(64, 8'h00, 1'b0, 1'b1);
    send_frame(64, 8'h80, 1'b1, 1'b0);
    send_frame(10, 8'hC0, 1'b0, 1'b0);
    send_frame(14, 8'hE0, 1'b0, 1'b1);
    idle(2);
    check_eq("t3_drop", drop_cnt, 2);
    check_eq("t3_level", level, 78);
    drain("t3", 20);

    // ---- test 4: depth-64 overflow, then wrap-around frame
    sel = 1'b1;
    send_byte(8'hFF, 1'b1, 1'b0);
    send_frame(40, 8'h10, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      send_byte(8'h60 + 8'(k), (k == 39), 1'b0);
      if (k == 24) check_eq("t4_drop_b24", drop_cnt, 0);
      if (k == 25) check_eq("t4_drop_b25", drop_cnt, 1);
    end
    idle(2);
    check_eq("t4_drop", drop_cnt, 1);
    check_eq("t4_level", level, 40);
    drain("t4a", 20);
    send_frame(30, 8'h30, 1'b0, 1'b1);
    idle(1);
    drain("t4b", 20);
    check_eq("t4_level_end", level, 0);
    check_eq("t4_drop_end", drop_cnt, 1);

    // ---- test 6: drop counter saturation
    force u_dut_s.r_drop_cnt = 16'hFFFE;
    @(negedge i_clk);
    release u_dut_s.r_drop_cnt;
    for (int f = 0; f < 3; f++) begin
      send_frame(14, 8'h55, 1'b1, 1'b0);
      idle(1);
      check_eq("t6_drop_sat", drop_cnt, 16'hFFFF);
    end
    check_eq("t6_level", level, 0);

    // ---- test 5: streaming stress on the 2048-deep instance
    sel = 1'b0;
    @(negedge i_clk);
    stress(40);
    check_eq("st_drop", drop_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
